display_timing_720p: RTL and testbench
======================================

Name: display_timing_720p

Overview:
- Generates 720p60 raster timing for the pixel pipeline, driven by the 74.25 MHz pixel clock.
- Drives signed screen coordinates to the combinational painter stage.
- Captures the painter's RGB response one cycle later.
- Emits hsync, vsync, data-enable and blanked RGB, all cycle-aligned, toward the TMDS/VGA output.

Parameters:
H_RES, 1280, active pixels per line
V_RES, 720, active lines per frame
H_FP, 110, horizontal front porch (pixels)
H_SYNC, 40, horizontal sync width (pixels)
H_BP, 220, horizontal back porch (pixels)
V_FP, 5, vertical front porch (lines)
V_SYNC, 5, vertical sync width (lines)
V_BP, 20, vertical back porch (lines)
SYNC_POL, 1, sync active level (1 = active-high)

Ports:
clk_pix  input  1  pixel clock; all logic on rising edge
rst_pix_n  input  1  asynchronous, active-low reset
o_sx  output  16 signed  current horizontal coordinate, to painter i_x
o_sy  output  16 signed  current vertical coordinate, to painter i_y
o_frame  output  1  high for one cycle when (o_sx,o_sy) = (H_STA,V_STA)
o_line  output  1  high for one cycle when o_sx = H_STA
i_red  input  8  painter red for current o_sx/o_sy
i_green  input  8  painter green
i_blue  input  8  painter blue
o_hsync  output  1  horizontal sync, aligned with o_red/o_green/o_blue
o_vsync  output  1  vertical sync, aligned
o_de  output  1  data enable, aligned
o_red  output  8  registered red; 0 when not enabled
o_green  output  8  registered green; 0 when not enabled
o_blue  output  8  registered blue; 0 when not enabled

Behaviour:
- Derived constants (signed 16-bit):
  - H_STA = -(H_FP+H_SYNC+H_BP) = -370; HS_STA = H_STA+H_FP = -260; HS_END = HS_STA+H_SYNC = -220; HA_END = H_RES-1 = 1279.
  - V_STA = -(V_FP+V_SYNC+V_BP) = -30; VS_STA = -25; VS_END = -20; VA_END = 719.
  - Totals: 1650 cycles/line, 750 lines/frame, 1,237,500 cycles/frame.
- Coordinate counters (registered; o_sx/o_sy driven directly from registers):
  - Async reset: sx=H_STA, sy=V_STA.
  - Each edge: if sx==HA_END then sx<=H_STA, else sx<=sx+1.
  - When sx==HA_END: if sy==VA_END then sy<=V_STA, else sy<=sy+1.
  - Wrap at HA_END/VA_END exactly; no value outside [H_STA,HA_END]×[V_STA,VA_END] ever appears.
- o_frame/o_line: combinational decode of the counter registers, aligned with o_sx/o_sy (stage 0).
- Stage 1 registers (1-cycle latency relative to o_sx/o_sy):
  - hs_raw = (sx>=HS_STA && sx<HS_END); vs_raw = (sy>=VS_STA && sy<VS_END); de_raw = (sx>=0 && sy>=0).
  - o_hsync <= SYNC_POL ? hs_raw : ~hs_raw; o_vsync likewise; o_de <= de_raw.
  - o_red/green/blue <= de_raw ? i_* : 0. RGB is sampled on the same edge as de_raw, i.e. the painter output for the coordinate that was on o_sx/o_sy during that cycle.
- Reset values:
  - o_sx=-370, o_sy=-30, o_frame=1, o_line=1, o_de=0, RGB=0.
  - o_hsync = o_vsync = inactive level (0 when SYNC_POL=1).
- Reset mid-frame: counters and stage 1 return immediately (asynchronously) to reset values. First post-reset cycle presents (H_STA,V_STA) with o_frame=1; the raster restarts cleanly with no partial-line artefacts beyond the aborted line.
- Painter contract: i_* must be a combinational function of o_sx/o_sy, settling within one clk_pix period. The block never registers o_sx.
- Arithmetic: all comparisons signed 16-bit; 16 bits covers range -370..1279 with margin.

Test Plan:
- Reset release: hold rst_pix_n=0 for 5 cycles then 1 -> first cycle o_sx=-370, o_sy=-30, o_frame=1, o_line=1; o_de=0, o_hsync=0, o_vsync=0, RGB=0.
- Line timing: count from o_line to next o_line -> 1650 cycles. o_hsync high for exactly 40 consecutive cycles, rising 1 cycle after o_sx=-260. o_de high for 1280 cycles per active line.
- Frame timing: o_frame to o_frame = 1,237,500 cycles. o_vsync high for 5 lines (8250 cycles), starting 1 cycle after (o_sx=-370, o_sy=-25). o_de high count per frame = 921,600.
- Wrap: at (o_sx=1279, o_sy=719) next cycle -> (-370,-30) with o_frame=1; at (1279,100) next -> (-370,101) with o_line=1 and o_frame=0.
- Data alignment/blanking: drive i_red = o_sx[7:0], i_green = o_sy[7:0], i_blue = 0x5A -> at o_de rising for line sy=360, o_red=0, o_green=0x68, o_blue=0x5A. At o_sx=-1 one cycle earlier, o_de=0 and RGB=0.
- Async reset mid-frame: assert rst_pix_n=0 between edges at (o_sx=640, o_sy=400) -> outputs return to reset values immediately without waiting for a clock edge. After release, the frame-length check again reads 1,237,500 cycles.

Source files
------------

// File: rtl/display_timing_720p.sv
// display_timing_720p
// Raster timing generator for 720p60 (74.25 MHz pixel clock).
// Coordinates run from a negative blanking start (H_STA/V_STA) up to the
// last active pixel, so the active area is simply sx>=0 && sy>=0.
//
// Ports
//   clk_pix, rst_pix_n      pixel clock, async active-low reset
//   o_sx, o_sy              signed coordinate to the painter (stage 0)
//   o_frame, o_line         start-of-frame / start-of-line strobes (stage 0)
//   i_red/i_green/i_blue    painter colour for the current o_sx/o_sy
//   o_hsync, o_vsync, o_de  syncs and data enable (stage 1)
//   o_red/o_green/o_blue    registered colour, zero outside the active area
module display_timing_720p #(
    parameter int H_RES    = 1280,
    parameter int V_RES    = 720,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic               clk_pix,
    input  logic               rst_pix_n,
    output logic signed [15:0] o_sx,
    output logic signed [15:0] o_sy,
    output logic               o_frame,
    output logic               o_line,
    input  logic [7:0]         i_red,
    input  logic [7:0]         i_green,
    input  logic [7:0]         i_blue,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_de,
    output logic [7:0]         o_red,
    output logic [7:0]         o_green,
    output logic [7:0]         o_blue
);

    localparam logic signed [15:0] H_STA  = 16'(-(H_FP + H_SYNC + H_BP));
    localparam logic signed [15:0] HS_STA = 16'(-(H_SYNC + H_BP));
    localparam logic signed [15:0] HS_END = 16'(-H_BP);
    localparam logic signed [15:0] HA_END = 16'(H_RES - 1);
    localparam logic signed [15:0] V_STA  = 16'(-(V_FP + V_SYNC + V_BP));
    localparam logic signed [15:0] VS_STA = 16'(-(V_SYNC + V_BP));
    localparam logic signed [15:0] VS_END = 16'(-V_BP);
    localparam logic signed [15:0] VA_END = 16'(V_RES - 1);

    // Sync level while not in the sync pulse.
    localparam logic SYNC_IDLE = ~SYNC_POL;

    logic signed [15:0] sx_q, sx_d;
    logic signed [15:0] sy_q, sy_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               de_q, de_d;
    logic [7:0]         red_q, red_d;
    logic [7:0]         green_q, green_d;
    logic [7:0]         blue_q, blue_d;
    logic               hs_raw, vs_raw, de_raw;

    always_comb begin
        sx_d = sx_q + 16'sd1;
        sy_d = sy_q;
        if (sx_q == HA_END) begin
            sx_d = H_STA;
            sy_d = (sy_q == VA_END) ? V_STA : sy_q + 16'sd1;
        end

        hs_raw = (sx_q >= HS_STA) && (sx_q < HS_END);
        vs_raw = (sy_q >= VS_STA) && (sy_q < VS_END);
        de_raw = (sx_q >= 16'sd0) && (sy_q >= 16'sd0);

        hsync_d = SYNC_POL ? hs_raw : ~hs_raw;
        vsync_d = SYNC_POL ? vs_raw : ~vs_raw;
        de_d    = de_raw;
        // Painter output belongs to the coordinate on o_sx/o_sy this cycle,
        // so it is captured alongside that coordinate's de/sync.
        red_d   = de_raw ? i_red   : 8'd0;
        green_d = de_raw ? i_green : 8'd0;
        blue_d  = de_raw ? i_blue  : 8'd0;
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            sx_q    <= H_STA;
            sy_q    <= V_STA;
            hsync_q <= SYNC_IDLE;
            vsync_q <= SYNC_IDLE;
            de_q    <= 1'b0;
            red_q   <= 8'd0;
            green_q <= 8'd0;
            blue_q  <= 8'd0;
        end else begin
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
        end
    end

    assign o_sx    = sx_q;
    assign o_sy    = sy_q;
    assign o_line  = (sx_q == H_STA);
    assign o_frame = (sx_q == H_STA) && (sy_q == V_STA);
    assign o_hsync = hsync_q;
    assign o_vsync = vsync_q;
    assign o_de    = de_q;
    assign o_red   = red_q;
    assign o_green = green_q;
    assign o_blue  = blue_q;

endmodule

// File: tb/tb_display_timing_720p.sv
// Directed bench: instance A uses the 720p defaults (reset, line timing,
// async reset); instance B uses a tiny raster with active-low syncs so a
// whole frame (17 x 12 = 204 cycles) can be checked cheaply.
module tb_display_timing_720p;

    logic clk = 1'b0;
    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;

    // Instance A: default 720p
    logic signed [15:0] a_sx, a_sy;
    logic a_frame, a_line, a_hs, a_vs, a_de;
    logic [7:0] a_ri, a_gi, a_bi, a_r, a_g, a_b;
    assign a_ri = a_sx[7:0];
    assign a_gi = a_sy[7:0];
    assign a_bi = 8'h5A;

    display_timing_720p dut_a (
        .clk_pix(clk), .rst_pix_n(rst_a_n), .o_sx(a_sx), .o_sy(a_sy),
        .o_frame(a_frame), .o_line(a_line), .i_red(a_ri), .i_green(a_gi),
        .i_blue(a_bi), .o_hsync(a_hs), .o_vsync(a_vs), .o_de(a_de),
        .o_red(a_r), .o_green(a_g), .o_blue(a_b));

    // Instance B: H 8/2/3/4 (17 per line), V 6/1/2/3 (12 lines), active-low
    logic signed [15:0] b_sx, b_sy;
    logic b_frame, b_line, b_hs, b_vs, b_de;
    logic [7:0] b_ri, b_gi, b_bi, b_r, b_g, b_b;
    assign b_ri = b_sx[7:0];
    assign b_gi = b_sy[7:0];
    assign b_bi = 8'h5A;

    display_timing_720p #(
        .H_RES(8), .V_RES(6), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_FP(1), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
    ) dut_b (
        .clk_pix(clk), .rst_pix_n(rst_b_n), .o_sx(b_sx), .o_sy(b_sy),
        .o_frame(b_frame), .o_line(b_line), .i_red(b_ri), .i_green(b_gi),
        .i_blue(b_bi), .o_hsync(b_hs), .o_vsync(b_vs), .o_de(b_de),
        .o_red(b_r), .o_green(b_g), .o_blue(b_b));

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Snapshots taken while running a frame on instance B
    logic signed [15:0] s135_sx, s135_sy, s136_sx, s136_sy, s203_sx, s203_sy;
    logic s136_line, s136_frame;
    logic [7:0] rise_r, rise_g, rise_b, pre_rgb, mid_r, mid_g;
    logic rise_seen;

    // Runs instance B from a start-of-frame until the next o_frame.
    task automatic run_frame_b(output int len, output int vs_cnt,
                               output int vs_first, output int hs_cnt,
                               output int de_cnt);
        logic prev_de;
        logic [7:0] prev_or;
        len = 0; vs_cnt = 0; vs_first = -1; hs_cnt = 0; de_cnt = 0;
        rise_seen = 1'b0;
        prev_de = b_de;
        prev_or = b_r | b_g | b_b;
        while (len < 1000) begin
            @(negedge clk);
            len++;
            if (!b_vs) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = len;
            end
            if (!b_hs) hs_cnt++;
            if (b_de) de_cnt++;
            if (b_de && !prev_de && b_sy == 16'sd3) begin
                rise_seen = 1'b1;
                rise_r = b_r; rise_g = b_g; rise_b = b_b; pre_rgb = prev_or;
            end
            if (b_sx == 16'sd5 && b_sy == 16'sd3) begin
                mid_r = b_r; mid_g = b_g;
            end
            if (len == 135) begin s135_sx = b_sx; s135_sy = b_sy; end
            if (len == 136) begin
                s136_sx = b_sx; s136_sy = b_sy;
                s136_line = b_line; s136_frame = b_frame;
            end
            if (len == 203) begin s203_sx = b_sx; s203_sy = b_sy; end
            prev_de = b_de;
            prev_or = b_r | b_g | b_b;
            if (b_frame) break;
        end
    endtask

    initial begin
        int k, hs_cnt, hs_first, de_cnt, vs_cnt, vs_first, len;

        // Reset held 5 cycles
        repeat (5) @(negedge clk);
        check("a_rst_sx", a_sx, -370);
        check("a_rst_sy", a_sy, -30);
        check("a_rst_frame", a_frame, 1);
        check("a_rst_line", a_line, 1);
        check("a_rst_de", a_de, 0);
        check("a_rst_hs", a_hs, 0);
        check("a_rst_vs", a_vs, 0);
        check("a_rst_rgb", {a_r, a_g, a_b}, 0);
        check("b_rst_hs_idle", b_hs, 1);
        check("b_rst_vs_idle", b_vs, 1);

        // Release A; this negedge is cycle 0 of the first line
        rst_a_n = 1'b1;
        check("a_rel_sx", a_sx, -370);
        check("a_rel_frame", a_frame, 1);

        k = 0; hs_cnt = 0; hs_first = -1; de_cnt = 0;
        while (k < 2000) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                check("a_step_sx", a_sx, -369);
                check("a_step_line", a_line, 0);
            end
            if (a_hs) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = k;
            end
            if (a_de) de_cnt++;
            if (a_line) break;
        end
        check("a_line_len", k, 1650);
        check("a_hs_width", hs_cnt, 40);
        check("a_hs_first", hs_first, 111);
        check("a_blank_de", de_cnt, 0);
        check("a_line2_sx", a_sx, -370);
        check("a_line2_sy", a_sy, -29);
        check("a_line2_frame", a_frame, 0);

        // Async reset mid-line at sx=640, between clock edges
        repeat (1010) @(negedge clk);
        check("a_mid_sx", a_sx, 640);
        #2 rst_a_n = 1'b0;
        #1;
        check("a_arst_sx", a_sx, -370);
        check("a_arst_sy", a_sy, -30);
        check("a_arst_frame", a_frame, 1);
        check("a_arst_hs", a_hs, 0);

        // Instance B: full frame
        @(negedge clk);
        rst_b_n = 1'b1;
        check("b_rel_sx", b_sx, -9);
        check("b_rel_sy", b_sy, -6);
        run_frame_b(len, vs_cnt, vs_first, hs_cnt, de_cnt);
        check("b_frame_len", len, 204);
        check("b_vs_width", vs_cnt, 34);
        check("b_vs_first", vs_first, 18);
        check("b_hs_per_frame", hs_cnt, 36);
        check("b_de_per_frame", de_cnt, 48);
        check("b_wrap_last_sx", s203_sx, 7);
        check("b_wrap_last_sy", s203_sy, 5);
        check("b_wrap_sx", b_sx, -9);
        check("b_wrap_sy", b_sy, -6);
        check("b_line_end_sx", s135_sx, 7);
        check("b_line_end_sy", s135_sy, 1);
        check("b_line_wrap_sx", s136_sx, -9);
        check("b_line_wrap_sy", s136_sy, 2);
        check("b_line_wrap_line", s136_line, 1);
        check("b_line_wrap_frame", s136_frame, 0);
        check("b_rise_seen", rise_seen, 1);
        check("b_rise_red", rise_r, 8'h00);
        check("b_rise_green", rise_g, 8'h03);
        check("b_rise_blue", rise_b, 8'h5A);
        check("b_pre_rise_rgb", pre_rgb, 0);
        check("b_mid_red", mid_r, 8'h04);
        check("b_mid_green", mid_g, 8'h03);

        // Async reset of B mid-frame, then a clean frame
        repeat (50) @(negedge clk);
        #2 rst_b_n = 1'b0;
        #1;
        check("b_arst_sx", b_sx, -9);
        check("b_arst_sy", b_sy, -6);
        check("b_arst_frame", b_frame, 1);
        check("b_arst_hs", b_hs, 1);
        check("b_arst_vs", b_vs, 1);
        check("b_arst_de", b_de, 0);
        check("b_arst_rgb", {b_r, b_g, b_b}, 0);
        @(negedge clk);
        rst_b_n = 1'b1;
        run_frame_b(len, vs_cnt, vs_first, hs_cnt, de_cnt);
        check("b_frame_len_after_rst", len, 204);
        check("b_de_after_rst", de_cnt, 48);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
